// File: rtl/uart_rx_pkg.sv
// Shared constants and helpers for the UART receive edge sampler.
package uart_rx_pkg;

    localparam int PRESCALE_W_DEF = 6;
    localparam int BIT_CNT_W_DEF  = 4;
    localparam int PRESCALE_MIN   = 8;
    localparam int BIT_CNT_MAX    = 15;

    // Clamp tiny ratios up to the minimum and round odd ratios down to even.
    function automatic logic [31:0] calc_eff_prescale(input logic [31:0] raw);
        logic [31:0] eff;
        if (raw < 32'(PRESCALE_MIN)) begin
            eff = 32'(PRESCALE_MIN);
        end else begin
            eff = raw & ~32'd1;
        end
        return eff;
    endfunction

endpackage

// File: rtl/uart_rx_majority3.sv
// Combinational 2-of-3 vote over the three mid-bit samples.
module uart_rx_majority3 (
    input  logic [2:0] votes,
    output logic       majority
);

    assign majority = (votes[0] & votes[1]) | (votes[0] & votes[2]) | (votes[1] & votes[2]);

endmodule

// File: rtl/uart_rx_edge_sampler.sv
// UART RX timing front end: oversample/bit counters and majority-voted mid-bit sampling.
// Optional 2-flop input synchronizer on rx_in when UART_RX_SYNC_EN is defined.
module uart_rx_edge_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = PRESCALE_W_DEF,
    parameter int BIT_CNT_W  = BIT_CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  dat_samp_en,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [PRESCALE_W-1:0] edge_count,
    output logic [BIT_CNT_W-1:0]  bit_count,
    output logic                  sampled_bit,
    output logic                  sample_valid
);

    logic [PRESCALE_W-1:0] edge_count_q, edge_count_d;
    logic [PRESCALE_W-1:0] eff_prescale_q, eff_prescale_d;
    logic [PRESCALE_W-1:0] mid;
    logic [BIT_CNT_W-1:0]  bit_count_q, bit_count_d;
    logic [2:0]            sample_q, sample_d;
    logic                  sampled_bit_q, sampled_bit_d;
    logic                  sample_valid_q, sample_valid_d;
    logic                  rx_src;
    logic                  maj_bit;

`ifdef UART_RX_SYNC_EN
    logic [1:0] rx_sync_q, rx_sync_d;

    assign rx_sync_d = {rx_sync_q[0], rx_in};
    assign rx_src    = rx_sync_q[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync_q <= 2'b11;
        end else begin
            rx_sync_q <= rx_sync_d;
        end
    end
`else
    assign rx_src = rx_in;
`endif

    uart_rx_majority3 u_majority (
        .votes    (sample_q),
        .majority (maj_bit)
    );

    always_comb begin
        mid            = eff_prescale_q >> 1;
        eff_prescale_d = eff_prescale_q;
        edge_count_d   = '0;
        bit_count_d    = '0;
        sample_d       = sample_q;
        sampled_bit_d  = sampled_bit_q;
        sample_valid_d = 1'b0;

        if (!enable) begin
            // Ratio only tracks the input while idle, so a frame keeps one bit period.
            eff_prescale_d = PRESCALE_W'(calc_eff_prescale(32'(prescale)));
        end else begin
            if (edge_count_q == eff_prescale_q - PRESCALE_W'(1)) begin
                edge_count_d = '0;
                if (bit_count_q == BIT_CNT_W'(BIT_CNT_MAX)) begin
                    bit_count_d = bit_count_q;
                end else begin
                    bit_count_d = bit_count_q + BIT_CNT_W'(1);
                end
            end else begin
                edge_count_d = edge_count_q + PRESCALE_W'(1);
                bit_count_d  = bit_count_q;
            end

            if (dat_samp_en) begin
                if ((edge_count_q == mid - PRESCALE_W'(1)) ||
                    (edge_count_q == mid) ||
                    (edge_count_q == mid + PRESCALE_W'(1))) begin
                    sample_d = {sample_q[1:0], rx_src};
                end
                if (edge_count_q == mid + PRESCALE_W'(2)) begin
                    sampled_bit_d  = maj_bit;
                    sample_valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            edge_count_q   <= '0;
            bit_count_q    <= '0;
            eff_prescale_q <= PRESCALE_W'(PRESCALE_MIN);
            sample_q       <= 3'b111;
            sampled_bit_q  <= 1'b1;
            sample_valid_q <= 1'b0;
        end else begin
            edge_count_q   <= edge_count_d;
            bit_count_q    <= bit_count_d;
            eff_prescale_q <= eff_prescale_d;
            sample_q       <= sample_d;
            sampled_bit_q  <= sampled_bit_d;
            sample_valid_q <= sample_valid_d;
        end
    end

    assign edge_count   = edge_count_q;
    assign bit_count    = bit_count_q;
    assign sampled_bit  = sampled_bit_q;
    assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_uart_rx_edge_sampler.sv
// Directed self-checking bench for uart_rx_edge_sampler (default build or UART_RX_SYNC_EN).
module tb_uart_rx_edge_sampler;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       dat_samp_en;
    logic       rx_in;
    logic [5:0] prescale;
    logic [5:0] edge_count;
    logic [3:0] bit_count;
    logic       sampled_bit;
    logic       sample_valid;

    int errors = 0;
    int checks = 0;

`ifdef UART_RX_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    uart_rx_edge_sampler dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .dat_samp_en  (dat_samp_en),
        .rx_in        (rx_in),
        .prescale     (prescale),
        .edge_count   (edge_count),
        .bit_count    (bit_count),
        .sampled_bit  (sampled_bit),
        .sample_valid (sample_valid)
    );

    always #5 clk = ~clk;

    // Inputs set before step() are taken at the next posedge; outputs read 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        assert (obs === 32'(exp)) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One bit period at ratio eff; line is 1 only at edge indices g1/g2 (sample-reg view).
    task automatic run_bit(input int eff, input int g1, input int g2, input int exp_bit, input string tag);
        int mid;
        int tgt;
        mid = eff / 2;
        for (int e = 0; e < eff; e++) begin
            tgt = (e + LAT) % eff;
            rx_in = ((tgt == g1) || (tgt == g2)) ? 1'b1 : 1'b0;
            step();
            if (e == mid + 2) begin
                chk({tag, "_valid"}, 32'(sample_valid), 1);
                chk({tag, "_bit"}, 32'(sampled_bit), exp_bit);
                chk({tag, "_edge"}, 32'(edge_count), mid + 3);
            end
        end
    endtask

    initial begin
        int pulses;

        // Reset state
        rst = 1'b1; enable = 1'b0; dat_samp_en = 1'b0; rx_in = 1'b0; prescale = 6'd8;
        step();
        chk("rst_edge", 32'(edge_count), 0);
        chk("rst_bit", 32'(bit_count), 0);
        chk("rst_sampled", 32'(sampled_bit), 1);
        chk("rst_valid", 32'(sample_valid), 0);

        // prescale=8, rx steady 0
        rst = 1'b0;
        step();
        enable = 1'b1; dat_samp_en = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            chk("p8_edge", 32'(edge_count), k % 8);
            chk("p8_bit", 32'(bit_count), k / 8);
            chk("p8_valid", 32'(sample_valid), (k % 8 == 7) ? 1 : 0);
            chk("p8_sampled", 32'(sampled_bit), (k >= 7) ? 0 : 1);
        end

        // prescale=16 majority vote with glitches
        enable = 1'b0; prescale = 6'd16;
        step();
        enable = 1'b1;
        run_bit(16, 7, 8, 1, "glitch2");
        run_bit(16, 8, -1, 0, "glitch1");

        // enable falls exactly on the capture edge: no pulse, no update
        enable = 1'b0; prescale = 6'd8;
        step();
        enable = 1'b1; rx_in = 1'b1;
        repeat (6) step();
        enable = 1'b0;
        step();
        chk("efall_valid", 32'(sample_valid), 0);
        chk("efall_sampled", 32'(sampled_bit), 0);
        chk("efall_edge", 32'(edge_count), 0);

        // prescale=32 bit counting and saturation
        dat_samp_en = 1'b0; prescale = 6'd32;
        step();
        enable = 1'b1;
        repeat (12 * 32) step();
        chk("p32_bit12", 32'(bit_count), 12 - 1 + 1);
        chk("p32_edge12", 32'(edge_count), 0);
        repeat (3 * 32) step();
        chk("p32_bit15", 32'(bit_count), 15);
        repeat (32) step();
        chk("p32_sat", 32'(bit_count), 15);
        enable = 1'b0;
        step();
        chk("p32_clr_edge", 32'(edge_count), 0);
        chk("p32_clr_bit", 32'(bit_count), 0);

        // prescale change while enabled is ignored until idle
        prescale = 6'd8;
        step();
        enable = 1'b1;
        repeat (3) step();
        prescale = 6'd16;
        repeat (4) step();
        chk("frz_edge7", 32'(edge_count), 7);
        step();
        chk("frz_wrap_edge", 32'(edge_count), 0);
        chk("frz_wrap_bit", 32'(bit_count), 1);
        enable = 1'b0;
        step();
        enable = 1'b1;
        repeat (15) step();
        chk("p16_edge15", 32'(edge_count), 15);
        step();
        chk("p16_wrap_edge", 32'(edge_count), 0);
        chk("p16_wrap_bit", 32'(bit_count), 1);

        // prescale=5 behaves as 8, prescale=17 behaves as 16
        enable = 1'b0; prescale = 6'd5;
        step();
        enable = 1'b1;
        repeat (7) step();
        chk("p5_edge7", 32'(edge_count), 7);
        step();
        chk("p5_wrap_edge", 32'(edge_count), 0);
        chk("p5_wrap_bit", 32'(bit_count), 1);
        enable = 1'b0; prescale = 6'd17;
        step();
        enable = 1'b1;
        repeat (15) step();
        chk("p17_edge15", 32'(edge_count), 15);
        step();
        chk("p17_wrap_edge", 32'(edge_count), 0);
        chk("p17_wrap_bit", 32'(bit_count), 1);

        // dat_samp_en=0 for a whole bit: no pulse, sampled_bit holds
        enable = 1'b0; prescale = 6'd8; dat_samp_en = 1'b0; rx_in = 1'b1;
        step();
        enable = 1'b1;
        pulses = 0;
        repeat (8) begin
            step();
            if (sample_valid === 1'b1) pulses++;
        end
        chk("nosamp_pulses", 32'(pulses), 0);
        chk("nosamp_sampled", 32'(sampled_bit), 0);

        // reset mid-frame, then eff_prescale back to 8 and frozen
        enable = 1'b0; rx_in = 1'b0;
        step();
        enable = 1'b1; dat_samp_en = 1'b1;
        repeat (7) step();
        chk("pre_rst_valid", 32'(sample_valid), 1);
        chk("pre_rst_sampled", 32'(sampled_bit), 0);
        rst = 1'b1; prescale = 6'd16;
        step();
        chk("mrst_edge", 32'(edge_count), 0);
        chk("mrst_bit", 32'(bit_count), 0);
        chk("mrst_sampled", 32'(sampled_bit), 1);
        chk("mrst_valid", 32'(sample_valid), 0);
        rst = 1'b0;
        repeat (7) step();
        chk("post_rst_edge7", 32'(edge_count), 7);
        step();
        chk("post_rst_wrap_edge", 32'(edge_count), 0);
        chk("post_rst_wrap_bit", 32'(bit_count), 1);

        enable = 1'b0;
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
